// File: rtl/demux_1x2_stream_if.sv
// Stream bundle for the 1:2 demux: one input stream, two output
// channels and per-channel beat counters.
interface demux_1x2_stream_if #(
  parameter int W = 8
);
  logic [W-1:0] d;
  logic         s;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] f0;
  logic [W-1:0] f1;
  logic         f0_valid;
  logic         f1_valid;
  logic         f0_ready;
  logic         f1_ready;
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;

  modport master (
    output d, s, in_valid, f0_ready, f1_ready,
    input  in_ready, f0, f1, f0_valid, f1_valid,
    input  cnt0, cnt1
  );

  modport slave (
    input  d, s, in_valid, f0_ready, f1_ready,
    output in_ready, f0, f1, f0_valid, f1_valid,
    output cnt0, cnt1
  );
endinterface

// File: rtl/demux_1x2_stream.sv
// 1:2 valid/ready stream demux; each channel owns a 2-entry FIFO
// so a stalled sink only blocks beats routed to itself.
module demux_1x2_stream #(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  demux_1x2_stream_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } st_e;

  st_e          st_q   [2];
  st_e          st_d   [2];
  logic [W-1:0] head_q [2];
  logic [W-1:0] head_d [2];
  logic [W-1:0] tail_q [2];
  logic [W-1:0] tail_d [2];
  logic [7:0]   cnt_q  [2];
  logic [7:0]   cnt_d  [2];

  logic [1:0] sel;
  logic [1:0] out_rdy;
  logic [1:0] push;
  logic [1:0] pop;
  logic       acc;

  // Ready looks only at the selected channel's registered state.
  assign bus.in_ready = (bus.s ? st_q[1] : st_q[0]) != FULL;
  assign acc          = bus.in_valid & bus.in_ready;
  assign sel          = {bus.s, ~bus.s};
  assign out_rdy      = {bus.f1_ready, bus.f0_ready};
  assign push         = sel & {2{acc}};

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      pop[k] = (st_q[k] != EMPTY) & out_rdy[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      st_d[k]   = st_q[k];
      head_d[k] = head_q[k];
      tail_d[k] = tail_q[k];
      cnt_d[k]  = cnt_q[k];
      unique case (st_q[k])
        EMPTY: begin
          if (push[k]) begin
            head_d[k] = bus.d;
            st_d[k]   = ONE;
          end
        end
        ONE: begin
          if (push[k] && pop[k]) begin
            head_d[k] = bus.d;
          end else if (push[k]) begin
            tail_d[k] = bus.d;
            st_d[k]   = FULL;
          end else if (pop[k]) begin
            st_d[k]   = EMPTY;
          end
        end
        FULL: begin
          if (pop[k]) begin
            head_d[k] = tail_q[k];
            st_d[k]   = ONE;
          end
        end
        default: st_d[k] = EMPTY;
      endcase
      if (push[k]) begin
        cnt_d[k] = cnt_q[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        st_q[k]   <= EMPTY;
        head_q[k] <= '0;
        tail_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        st_q[k]   <= st_d[k];
        head_q[k] <= head_d[k];
        tail_q[k] <= tail_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  assign bus.f0       = head_q[0];
  assign bus.f1       = head_q[1];
  assign bus.f0_valid = st_q[0] != EMPTY;
  assign bus.f1_valid = st_q[1] != EMPTY;
  assign bus.cnt0     = cnt_q[0];
  assign bus.cnt1     = cnt_q[1];

endmodule

// File: tb/tb_demux_1x2_stream.sv
// Bench for demux_1x2_stream: directed scenarios plus a random run
// against a two-queue reference model.
module tb_demux_1x2_stream;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_1x2_stream_if #(.W(W)) bus ();

  demux_1x2_stream #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.d        = '0;
    bus.s        = 1'b0;
    bus.in_valid = 1'b0;
    bus.f0_ready = 1'b0;
    bus.f1_ready = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    idle();
    #12;
    checks += 6;
    if (bus.f0_valid !== 1'b0) begin
      errors++; $display("FAIL rst_f0_valid got %b want 0", bus.f0_valid);
    end
    if (bus.f1_valid !== 1'b0) begin
      errors++; $display("FAIL rst_f1_valid got %b want 0", bus.f1_valid);
    end
    if (bus.f0 !== 8'h00 || bus.f1 !== 8'h00) begin
      errors++; $display("FAIL rst_data got %h/%h want 00/00", bus.f0, bus.f1);
    end
    if (bus.cnt0 !== 8'd0) begin
      errors++; $display("FAIL rst_cnt0 got %0d want 0", bus.cnt0);
    end
    if (bus.cnt1 !== 8'd0) begin
      errors++; $display("FAIL rst_cnt1 got %0d want 0", bus.cnt1);
    end
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.s = 1'b0;
    bus.d = 8'hA1;
    tick();
    bus.d = 8'hA2;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.f0 !== 8'hA1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_fill got f0=%h rdy=%b want A1/0", bus.f0, bus.in_ready);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.f0_valid !== 1'b0 || bus.f0 !== 8'h00 ||
        bus.cnt0 !== 8'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got v=%b f0=%h c=%0d rdy=%b want 0/00/0/1",
               bus.f0_valid, bus.f0, bus.cnt0, bus.in_ready);
    end
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.d = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.f0_valid !== 1'b1 || bus.f0 !== 8'h55 || bus.cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL post_rst got v=%b f0=%h c=%0d want 1/55/1",
               bus.f0_valid, bus.f0, bus.cnt0);
    end
  endtask

  task automatic test_routing;
    logic [7:0] vals [4];
    logic       sels [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    sels = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus.f0_ready = 1'b1;
    bus.f1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.d = vals[i];
      bus.s = sels[i];
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL route_rdy%0d got %b want 1", i, bus.in_ready);
      end
      tick();
      checks++;
      if (sels[i] == 1'b0 && (bus.f0 !== vals[i] || bus.f0_valid !== 1'b1)) begin
        errors++; $display("FAIL route_f0_%0d got %h want %h", i, bus.f0, vals[i]);
      end
      if (sels[i] == 1'b1 && (bus.f1 !== vals[i] || bus.f1_valid !== 1'b1)) begin
        errors++; $display("FAIL route_f1_%0d got %h want %h", i, bus.f1, vals[i]);
      end
    end
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.cnt0 !== 8'd2 || bus.cnt1 !== 8'd2) begin
      errors++;
      $display("FAIL route_cnt got %0d/%0d want 2/2", bus.cnt0, bus.cnt1);
    end
  endtask

  task automatic test_full_blocking;
    do_reset();
    bus.in_valid = 1'b1;
    bus.s = 1'b1;
    bus.d = 8'h01;
    tick();
    bus.d = 8'h02;
    tick();
    bus.d = 8'h03;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.f1 !== 8'h01) begin
      errors++;
      $display("FAIL full_block got rdy=%b f1=%h want 0/01", bus.in_ready, bus.f1);
    end
    bus.s = 1'b0;
    bus.d = 8'h0A;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL other_ch_rdy got %b want 1", bus.in_ready);
    end
    tick();
    bus.s = 1'b1;
    bus.d = 8'h03;
    bus.f1_ready = 1'b1;
    #1;
    checks++;
    if (bus.f0 !== 8'h0A || bus.f0_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL side_push got f0=%h v=%b rdy=%b want 0A/1/0",
               bus.f0, bus.f0_valid, bus.in_ready);
    end
    tick();
    bus.f1_ready = 1'b0;
    #1;
    checks++;
    if (bus.f1 !== 8'h02 || bus.in_ready !== 1'b1 || bus.cnt1 !== 8'd2) begin
      errors++;
      $display("FAIL after_pop got f1=%h rdy=%b c=%0d want 02/1/2",
               bus.f1, bus.in_ready, bus.cnt1);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.f1_ready = 1'b1;
    #1;
    checks++;
    if (bus.cnt1 !== 8'd3 || bus.cnt0 !== 8'd1) begin
      errors++;
      $display("FAIL full_cnt got %0d/%0d want 1/3", bus.cnt0, bus.cnt1);
    end
    tick();
    checks++;
    if (bus.f1 !== 8'h03 || bus.f1_valid !== 1'b1) begin
      errors++;
      $display("FAIL late_beat got f1=%h v=%b want 03/1", bus.f1, bus.f1_valid);
    end
  endtask

  task automatic test_push_pop_one;
    do_reset();
    bus.in_valid = 1'b1;
    bus.s = 1'b0;
    bus.d = 8'h10;
    tick();
    bus.d = 8'h20;
    bus.f0_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.f0_ready = 1'b0;
    #1;
    checks++;
    if (bus.f0 !== 8'h20 || bus.f0_valid !== 1'b1 ||
        bus.in_ready !== 1'b1 || bus.cnt0 !== 8'd2) begin
      errors++;
      $display("FAIL pushpop got f0=%h v=%b rdy=%b c=%0d want 20/1/1/2",
               bus.f0, bus.f0_valid, bus.in_ready, bus.cnt0);
    end
    bus.f0_ready = 1'b1;
    tick();
    checks++;
    if (bus.f0_valid !== 1'b0) begin
      errors++; $display("FAIL pushpop_drain got v=%b want 0", bus.f0_valid);
    end
  endtask

  task automatic test_counter_wrap;
    do_reset();
    bus.f1_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.s = 1'b1;
    for (int i = 0; i < 257; i++) begin
      bus.d = 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.cnt1 !== 8'd1 || bus.cnt0 !== 8'd0) begin
      errors++;
      $display("FAIL wrap got %0d/%0d want 0/1", bus.cnt0, bus.cnt1);
    end
  endtask

  task automatic test_random;
    logic [7:0] q [2][$];
    int         n [2];
    logic       rdy_m;
    logic [1:0] rdy_o;
    int         bad;
    do_reset();
    n[0] = 0;
    n[1] = 0;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.s        = 1'($urandom_range(0, 1));
      bus.d        = 8'($urandom);
      bus.f0_ready = ($urandom_range(0, 3) != 0);
      bus.f1_ready = ($urandom_range(0, 2) != 0);
      #1;
      rdy_m = q[bus.s].size() < 2;
      checks++;
      if (bus.in_ready !== rdy_m) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rnd_rdy c=%0d got %b want %b", c, bus.in_ready, rdy_m);
      end
      checks++;
      if (bus.f0_valid !== (q[0].size() > 0) ||
          bus.f1_valid !== (q[1].size() > 0)) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rnd_valid c=%0d got %b%b want %0d/%0d", c,
                   bus.f0_valid, bus.f1_valid, q[0].size(), q[1].size());
      end
      if (q[0].size() > 0) begin
        checks++;
        if (bus.f0 !== q[0][0]) begin
          errors++; bad++;
          if (bad < 10)
            $display("FAIL rnd_f0 c=%0d got %h want %h", c, bus.f0, q[0][0]);
        end
      end
      if (q[1].size() > 0) begin
        checks++;
        if (bus.f1 !== q[1][0]) begin
          errors++; bad++;
          if (bad < 10)
            $display("FAIL rnd_f1 c=%0d got %h want %h", c, bus.f1, q[1][0]);
        end
      end
      checks++;
      if (bus.cnt0 !== 8'(n[0]) || bus.cnt1 !== 8'(n[1])) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rnd_cnt c=%0d got %0d/%0d want %0d/%0d", c,
                   bus.cnt0, bus.cnt1, n[0] % 256, n[1] % 256);
      end
      rdy_o = {bus.f1_ready, bus.f0_ready};
      for (int k = 0; k < 2; k++) begin
        if (q[k].size() > 0 && rdy_o[k]) void'(q[k].pop_front());
      end
      if (bus.in_valid && rdy_m) begin
        q[bus.s].push_back(bus.d);
        n[bus.s]++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_routing();
    test_full_blocking();
    test_push_pop_one();
    test_counter_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x2_stream.md
# demux_1x2_stream

Routes a valid/ready data stream to one of two output channels, selected per beat by `s`. It is the receiving-end counterpart of the 2:1 selection path and performs the inverse operation: one source feeds two sinks. Each output channel has its own 2-entry FIFO, so a stalled sink does not block traffic to the other sink until that sink's own FIFO fills. Per-channel beat counters support debug and verification.

## Interface
- `W`, default 8: data width in bits.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `d` input W: input data.
- `s` input 1: destination select for the current beat (0 routes to channel 0, 1 routes to channel 1).
- `in_valid` input 1: the input beat on `d`/`s` is valid.
- `in_ready` output 1: the block can accept the current beat.
- `f0`, `f1` output W: head-of-FIFO data for channel 0 and channel 1.
- `f0_valid`, `f1_valid` output 1: the matching channel FIFO is not empty.
- `f0_ready`, `f1_ready` input 1: the sink accepts the head beat.
- `cnt0`, `cnt1` output 8: count of beats accepted into each channel, modulo 256.

## Operation
- **Acceptance.** An input beat is accepted when `in_valid & in_ready`.
  - `in_ready = ~full[s]`. It depends only on `s` and registered state; there is no combinational path from `f*_ready`.
- **Routing.** An accepted beat is written to the tail of FIFO[s]. The other FIFO is untouched.
- **Output.** An output beat is popped from channel k when `fk_valid & fk_ready`.
  - `fk = head of FIFO k` when valid. When empty, `fk` holds its last value; this is don't-care but must not be X after reset.
- **FIFO state machine.** Each FIFO is independent, with states EMPTY, ONE and FULL.
  - EMPTY: push goes to ONE. A pop cannot happen because valid is 0.
  - ONE:
    - push only goes to FULL;
    - pop only goes to EMPTY;
    - push and pop in the same cycle stay in ONE, with the new beat becoming head.
  - FULL: pop goes to ONE. A push is impossible because `in_ready` is 0 when `s` selects this channel.
- **Ordering.** Beats routed to the same channel leave in acceptance order. There is no ordering relation between the two channels.
- **Counters.** `cntk` increments by 1 on each beat accepted into channel k and wraps from 255 to 0.
- **Simultaneous events.**
  - A push to channel 0 and pops on both channels in the same cycle must all take effect.
  - A full channel 1 does not stall beats with `s=0`.
- **Reset values** (on assertion of `rst`, any time, including mid-transfer): both FIFOs EMPTY and pending beats discarded, `f0_valid=f1_valid=0`, `f0=f1=0`, `cnt0=cnt1=0`.
  - `in_ready` is then purely `~full[s]`, so it reads 1.
  - After release, the first beat may be accepted on the first rising edge with `rst` low.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears at `fk`/`fk_valid` after edge N, and is poppable at edge N+1 at the earliest.
- Throughput is 1 beat/cycle to one channel when that sink is always ready.
  - Alternating `s` with both sinks ready also sustains 1 beat/cycle.
- A channel holds at most 2 beats. With its sink stalled, the 3rd beat to that channel sees `in_ready=0` until the cycle after the first pop.
- `cntk` updates on the same edge as the push.

## Test plan
- **Reset mid-operation.** Fill channel 0 with 0xA1 and 0xA2, assert `rst` asynchronously between edges, then release → immediately `f0_valid=0`, `f0=0`, `cnt0=0`, `in_ready=1`. After release, send 0x55 with `s=0` → it is output after 1 cycle.
- **Routing and order.** Both sinks ready; send 0x11(s=0), 0x22(s=1), 0x33(s=0), 0x44(s=1) back-to-back → `f0` shows 0x11 then 0x33, `f1` shows 0x22 then 0x44, `in_ready` stays 1 throughout, and `cnt0=cnt1=2`.
- **Full and blocking.** Hold `f1_ready=0`; send 0x01, 0x02, 0x03 with `s=1` → the first two are accepted and `in_ready=0` with 0x03 pending. Meanwhile send 0x0A with `s=0` → accepted. Raise `f1_ready` for one cycle → 0x01 pops, and 0x03 is accepted on the following edge.
- **Push and pop on ONE.** Channel 0 holds 0x10 with `f0_ready=1`; send 0x20 with `s=0` in the same cycle → the state stays ONE, `f0=0x20` on the next cycle, and nothing is lost.
- **Counter wrap.** Stream 257 beats to channel 1 with the sink always ready → `cnt1=1` and `cnt0=0`.
- **Randomized check.** Drive random `in_valid`, `s`, `f0_ready` and `f1_ready` for 10k cycles against a scoreboard with two reference queues → no loss, duplication or reordering per channel, and counters match the reference counts modulo 256.
